// File: rtl/dm_access_ctrl.sv
// rtl/dm_access_ctrl.sv - M-stage load/store sequencer with alignment/range checks and timed req/ack
module dm_access_ctrl #(
    parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_2FFF,
    parameter int          TIMEOUT    = 16,
    parameter int          CNT_W      = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [2:0]  resp_ext_op,
    output logic [1:0]  resp_ext_a,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        exc_bus,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_byteen,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             acc_we;
    logic [1:0]       acc_a;
    logic [2:0]       acc_op;

    logic             aligned, in_range, legal, timeout;
    logic [3:0]       be_dec;
    logic [31:0]      wdata_dec;
    logic [2:0]       op_dec;

    // Signed 33-bit compares keep the bound checks meaningful even when a bound is zero.
    assign in_range = ($signed({1'b0, req_addr}) >= $signed({1'b0, ADDR_BASE})) &&
                      ($signed({1'b0, req_addr}) <= $signed({1'b0, ADDR_LIMIT}));
    assign legal    = aligned && in_range;
    assign timeout  = (cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        aligned   = 1'b0;
        be_dec    = 4'b0000;
        wdata_dec = 32'h0;
        op_dec    = 3'd0;
        case (req_size)
            2'd0: begin
                aligned   = (req_addr[1:0] == 2'b00);
                be_dec    = 4'b1111;
                wdata_dec = req_wdata;
            end
            2'd1: begin
                aligned   = ~req_addr[0];
                be_dec    = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_dec = {2{req_wdata[15:0]}};
                op_dec    = req_unsigned ? 3'd3 : 3'd4;
            end
            2'd2: begin
                aligned   = 1'b1;
                be_dec    = 4'b0001 << req_addr[1:0];
                wdata_dec = {4{req_wdata[7:0]}};
                op_dec    = req_unsigned ? 3'd1 : 3'd2;
            end
            default: aligned = 1'b0;
        endcase
        if (req_we) begin
            op_dec = 3'd0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = legal ? REQ : DONE;
            REQ:     if (mem_ack || timeout) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign stall      = ((state == IDLE) && req_valid) || (state == REQ);
    assign mem_req    = (state == REQ);
    assign resp_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            acc_we      <= 1'b0;
            acc_a       <= 2'b00;
            acc_op      <= 3'd0;
            resp_rdata  <= 32'h0;
            resp_ext_op <= 3'd0;
            resp_ext_a  <= 2'b00;
            exc_adel    <= 1'b0;
            exc_ades    <= 1'b0;
            exc_bus     <= 1'b0;
            mem_addr    <= 32'h0;
            mem_we      <= 1'b0;
            mem_byteen  <= 4'b0000;
            mem_wdata   <= 32'h0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (req_valid) begin
                    acc_we <= req_we;
                    acc_a  <= req_addr[1:0];
                    acc_op <= op_dec;
                    cnt    <= '0;
                    if (legal) begin
                        mem_addr   <= {req_addr[31:2], 2'b00};
                        mem_we     <= req_we;
                        mem_byteen <= req_we ? be_dec : 4'b0000;
                        mem_wdata  <= req_we ? wdata_dec : 32'h0;
                    end else begin
                        exc_adel    <= ~req_we;
                        exc_ades    <= req_we;
                        resp_rdata  <= 32'h0;
                        resp_ext_op <= 3'd0;
                        resp_ext_a  <= req_addr[1:0];
                    end
                end
                REQ: begin
                    // Ack takes priority over a coincident timeout.
                    if (mem_ack || timeout) begin
                        resp_rdata  <= (mem_ack && !acc_we) ? mem_rdata : 32'h0;
                        resp_ext_op <= mem_ack ? acc_op : 3'd0;
                        resp_ext_a  <= acc_a;
                        exc_bus     <= ~mem_ack;
                        mem_addr    <= 32'h0;
                        mem_we      <= 1'b0;
                        mem_byteen  <= 4'b0000;
                        mem_wdata   <= 32'h0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    exc_adel <= 1'b0;
                    exc_ades <= 1'b0;
                    exc_bus  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
